// File: rtl/pc_branch_unit.sv
// Program counter with conditional branches, latched ALU status and a small
// return-address stack; every output comes straight from a register.
module pc_branch_unit #(
  parameter logic [7:0]  RESET_PC    = 8'h00,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] alu_flags,
  input  logic       flags_we,
  input  logic [2:0] branch_op,
  input  logic [7:0] target,
  input  logic       stall,
  output logic [7:0] pc,
  output logic [2:0] status,
  output logic       taken,
  output logic [2:0] depth,
  output logic       stack_err
);
  localparam int         AW   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [2:0] DMAX = 3'(STACK_DEPTH);

  typedef enum logic [2:0] {
    OP_NONE, OP_JMP, OP_BZ, OP_BNZ, OP_BN, OP_BV, OP_CALL, OP_RET
  } op_e;

  op_e           op;
  logic [7:0]    stk [STACK_DEPTH];
  logic [7:0]    pc_inc, pc_nxt;
  logic [2:0]    depth_nxt;
  logic          taken_nxt, push, err_set;
  logic [AW-1:0] wr_idx, rd_idx;

  assign op     = op_e'(branch_op);
  assign pc_inc = pc + 8'd1;
  assign wr_idx = depth[AW-1:0];
  assign rd_idx = AW'(depth - 3'd1);

  // Conditions look only at the registered status, so a same-edge flag write
  // cannot influence the branch it coincides with.
  always_comb begin
    pc_nxt    = pc_inc;
    depth_nxt = depth;
    taken_nxt = 1'b0;
    push      = 1'b0;
    err_set   = 1'b0;
    case (op)
      OP_NONE: ;
      OP_JMP:  begin pc_nxt = target; taken_nxt = 1'b1; end
      OP_BZ:   if (status[2])  begin pc_nxt = target; taken_nxt = 1'b1; end
      OP_BNZ:  if (!status[2]) begin pc_nxt = target; taken_nxt = 1'b1; end
      OP_BN:   if (status[1])  begin pc_nxt = target; taken_nxt = 1'b1; end
      OP_BV:   if (status[0])  begin pc_nxt = target; taken_nxt = 1'b1; end
      OP_CALL: begin
        if (depth < DMAX) begin
          push      = 1'b1;
          depth_nxt = depth + 3'd1;
          pc_nxt    = target;
          taken_nxt = 1'b1;
        end else begin
          err_set = 1'b1;
        end
      end
      OP_RET: begin
        if (depth != 3'd0) begin
          depth_nxt = depth - 3'd1;
          pc_nxt    = stk[rd_idx];
          taken_nxt = 1'b1;
        end else begin
          err_set = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      status    <= 3'b000;
      taken     <= 1'b0;
      depth     <= 3'd0;
      stack_err <= 1'b0;
    end else if (stall) begin
      taken <= 1'b0;
    end else begin
      pc    <= pc_nxt;
      taken <= taken_nxt;
      depth <= depth_nxt;
      if (flags_we) status    <= alu_flags;
      if (err_set)  stack_err <= 1'b1;
    end
  end

  // Entries at or above depth are never read, so contents need no reset.
  always_ff @(posedge clk) begin
    if (!stall && push) stk[wr_idx] <= pc_inc;
  end
endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed vectors for pc_branch_unit; expectations are queued per edge and a
// monitor compares them after each rising clock.
module tb_pc_branch_unit;
  localparam logic [2:0] NONE = 3'd0, JMP = 3'd1, BZ = 3'd2, BNZ = 3'd3,
                         BN = 3'd4, BV = 3'd5, CALL = 3'd6, RET = 3'd7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] alu_flags = 3'b000;
  logic       flags_we = 1'b0;
  logic [2:0] branch_op = NONE;
  logic [7:0] target = 8'h00;
  logic       stall = 1'b0;
  logic [7:0] pc;
  logic [2:0] status;
  logic       taken;
  logic [2:0] depth;
  logic       stack_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string      nm;
    logic [7:0] pc;
    logic [2:0] st;
    logic       tk;
    logic [2:0] dp;
    logic       er;
  } exp_t;
  exp_t q[$];

  pc_branch_unit #(.RESET_PC(8'h00), .STACK_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .alu_flags(alu_flags), .flags_we(flags_we),
    .branch_op(branch_op), .target(target), .stall(stall),
    .pc(pc), .status(status), .taken(taken), .depth(depth), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endfunction

  task automatic chk_all(string nm, logic [7:0] epc, logic [2:0] est, logic etk,
                         logic [2:0] edp, logic eer);
    chk({nm, ".pc"}, pc, epc);
    chk({nm, ".status"}, {5'd0, status}, {5'd0, est});
    chk({nm, ".taken"}, {7'd0, taken}, {7'd0, etk});
    chk({nm, ".depth"}, {5'd0, depth}, {5'd0, edp});
    chk({nm, ".stack_err"}, {7'd0, stack_err}, {7'd0, eer});
  endtask

  // Drive one cycle of inputs, queue the result expected after the next edge.
  task automatic step(string nm, logic [2:0] op, logic [7:0] tg, logic fw,
                      logic [2:0] fl, logic st, logic [7:0] epc, logic [2:0] est,
                      logic etk, logic [2:0] edp, logic eer);
    exp_t e;
    branch_op = op; target = tg; flags_we = fw; alu_flags = fl; stall = st;
    e.nm = nm; e.pc = epc; e.st = est; e.tk = etk; e.dp = edp; e.er = eer;
    q.push_back(e);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk_all(e.nm, e.pc, e.st, e.tk, e.dp, e.er);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    #12;
    chk_all("reset", 8'h00, 3'b000, 1'b0, 3'd0, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    //       name        op    tgt    fw  flags   st   pc     stat    tk  dp  er
    step("seq1",   NONE, 8'h00, 0, 3'b000, 0, 8'h01, 3'b000, 0, 0, 0);
    step("seq2",   NONE, 8'h00, 0, 3'b000, 0, 8'h02, 3'b000, 0, 0, 0);
    step("seq3",   NONE, 8'h00, 0, 3'b000, 0, 8'h03, 3'b000, 0, 0, 0);
    step("jmpfe",  JMP,  8'hFE, 0, 3'b000, 0, 8'hFE, 3'b000, 1, 0, 0);
    step("incff",  NONE, 8'h00, 0, 3'b000, 0, 8'hFF, 3'b000, 0, 0, 0);
    step("wrap",   NONE, 8'h00, 0, 3'b000, 0, 8'h00, 3'b000, 0, 0, 0);
    step("jmp40",  JMP,  8'h40, 0, 3'b000, 0, 8'h40, 3'b000, 1, 0, 0);
    step("inc41",  NONE, 8'h00, 0, 3'b000, 0, 8'h41, 3'b000, 0, 0, 0);
    step("bzold",  BZ,   8'h20, 1, 3'b100, 0, 8'h42, 3'b100, 0, 0, 0);
    step("bznew",  BZ,   8'h20, 0, 3'b000, 0, 8'h20, 3'b100, 1, 0, 0);
    step("bnznt",  BNZ,  8'h30, 0, 3'b000, 0, 8'h21, 3'b100, 0, 0, 0);
    step("bnpc1",  BN,   8'h22, 0, 3'b000, 0, 8'h22, 3'b100, 0, 0, 0);
    step("bvold",  BV,   8'h90, 1, 3'b011, 0, 8'h23, 3'b011, 0, 0, 0);
    step("bn",     BN,   8'h70, 0, 3'b000, 0, 8'h70, 3'b011, 1, 0, 0);
    step("bv",     BV,   8'h10, 0, 3'b000, 0, 8'h10, 3'b011, 1, 0, 0);
    step("bznt",   BZ,   8'h55, 0, 3'b000, 0, 8'h11, 3'b011, 0, 0, 0);
    step("bnz",    BNZ,  8'h10, 0, 3'b000, 0, 8'h10, 3'b011, 1, 0, 0);
    step("call50", CALL, 8'h50, 0, 3'b000, 0, 8'h50, 3'b011, 1, 1, 0);
    step("call60", CALL, 8'h60, 0, 3'b000, 0, 8'h60, 3'b011, 1, 2, 0);
    step("ret51",  RET,  8'h00, 0, 3'b000, 0, 8'h51, 3'b011, 1, 1, 0);
    step("ret11",  RET,  8'h00, 0, 3'b000, 0, 8'h11, 3'b011, 1, 0, 0);
    step("callA",  CALL, 8'h20, 0, 3'b000, 0, 8'h20, 3'b011, 1, 1, 0);
    step("callB",  CALL, 8'h30, 0, 3'b000, 0, 8'h30, 3'b011, 1, 2, 0);
    step("callC",  CALL, 8'h40, 0, 3'b000, 0, 8'h40, 3'b011, 1, 3, 0);
    step("callD",  CALL, 8'h50, 0, 3'b000, 0, 8'h50, 3'b011, 1, 4, 0);
    step("ovf",    CALL, 8'h60, 0, 3'b000, 0, 8'h51, 3'b011, 0, 4, 1);
    step("ret41",  RET,  8'h00, 0, 3'b000, 0, 8'h41, 3'b011, 1, 3, 1);
    step("call70", CALL, 8'h70, 0, 3'b000, 0, 8'h70, 3'b011, 1, 4, 1);
    #2 rst_n = 1'b0;
    #1 chk_all("midrst", 8'h00, 3'b000, 1'b0, 3'd0, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    step("udf",    RET,  8'h00, 0, 3'b000, 0, 8'h01, 3'b000, 0, 0, 1);
    step("flags",  NONE, 8'h00, 1, 3'b110, 0, 8'h02, 3'b110, 0, 0, 1);
    step("call30", CALL, 8'h30, 0, 3'b000, 0, 8'h30, 3'b110, 1, 1, 1);
    step("stall1", JMP,  8'h80, 1, 3'b001, 1, 8'h30, 3'b110, 0, 1, 1);
    step("stall2", JMP,  8'h80, 1, 3'b001, 1, 8'h30, 3'b110, 0, 1, 1);
    step("post",   NONE, 8'h00, 0, 3'b000, 0, 8'h31, 3'b110, 0, 1, 1);
    step("ret03",  RET,  8'h00, 0, 3'b000, 0, 8'h03, 3'b110, 1, 0, 1);
    #2 rst_n = 1'b0;
    #1 chk_all("asyncrst", 8'h00, 3'b000, 1'b0, 3'd0, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
